// File: rtl/eth_rx_ring_sched.sv
// eth_rx_ring_sched
//   RX-side buffer-ring scheduler. Filters the byte stream from the GMII RX
//   block on destination MAC, writes frame bytes into the slot that nextbuf
//   points at, and commits the frame length. After a commit it advances the
//   producer pointer nextbuf, checked against the synchronised software
//   consumer pointer.
//
//   Optional feature: define ETH_RX_STATS_EN to build the four 16-bit
//   saturating stat_* counters. Without it, stat_* read 0 and stats_clr is
//   ignored.
//
// Ports
//   i_erx_clk, rstn              clock, synchronous active-low reset
//   rx_tdata/tvalid/tlast/tuser  AXIS byte stream, no backpressure
//   mac_address, promiscuous     destination filter controls
//   firstbuf_i                   consumer pointer (other clock domain)
//   wr_en/wr_addr/wr_data        packet-RAM byte write port (registered)
//   len_we/len_slot/len_value    length-table commit port (registered)
//   nextbuf, full                producer pointer, ring-full flag
//   stat_*, stats_clr            frame counters and their clear
module eth_rx_ring_sched #(
    parameter int NBUF_LOG2      = 3,
    parameter int BUF_BYTES_LOG2 = 11,
    parameter int MIN_LEN        = 60
) (
    input  logic                                i_erx_clk,
    input  logic                                rstn,
    input  logic [7:0]                          rx_tdata,
    input  logic                                rx_tvalid,
    input  logic                                rx_tlast,
    input  logic                                rx_tuser,
    input  logic [47:0]                         mac_address,
    input  logic                                promiscuous,
    input  logic [NBUF_LOG2:0]                  firstbuf_i,
    output logic                                wr_en,
    output logic [NBUF_LOG2+BUF_BYTES_LOG2-1:0] wr_addr,
    output logic [7:0]                          wr_data,
    output logic                                len_we,
    output logic [NBUF_LOG2-1:0]                len_slot,
    output logic [BUF_BYTES_LOG2-1:0]           len_value,
    output logic [NBUF_LOG2:0]                  nextbuf,
    output logic                                full,
    output logic [15:0]                         stat_rx_ok,
    output logic [15:0]                         stat_drop_full,
    output logic [15:0]                         stat_drop_filt,
    output logic [15:0]                         stat_drop_err,
    input  logic                                stats_clr
);
    localparam int PW = NBUF_LOG2 + 1;
    localparam int CW = BUF_BYTES_LOG2 + 1;
    localparam logic [PW-1:0] WRAP     = {1'b1, {NBUF_LOG2{1'b0}}};
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_LEN);
    localparam logic [CW-1:0] LAST_OFF = CW'((1 << BUF_BYTES_LOG2) - 1);

    typedef enum logic [2:0] {IDLE, HDR, ACCEPT, DISCARD, COMMIT} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     count, count_n;
    logic [39:0]       dmac, dmac_n;      // first five DA bytes; the sixth is the live byte
    logic [PW-1:0]     fb_s1, fb_s2;
    logic              mid;               // upstream is between a first and a last beat
    logic [47:0]       dmac_sh;
    logic              hit;
    logic [PW-1:0]     admit_ptr;
    logic              admit_full;
    logic              wr_go, commit;
    logic [NBUF_LOG2-1:0]      wr_slot;
    logic [BUF_BYTES_LOG2-1:0] wr_off;
    logic              inc_ok, inc_full, inc_filt, inc_err;

    assign dmac_sh = {dmac, rx_tdata};
    assign hit = (dmac_sh == mac_address) || (dmac_sh == 48'hFFFF_FFFF_FFFF) ||
                 (dmac_sh[47:24] == 24'h01005E) || promiscuous;

    // A beat taken in the COMMIT cycle belongs to the next frame, so it is
    // admitted against the pointer value that takes effect after this commit.
    assign admit_ptr  = (state == COMMIT) ? nextbuf + 1'b1 : nextbuf;
    assign admit_full = (admit_ptr == (fb_s2 ^ WRAP));
    assign full       = (nextbuf == (fb_s2 ^ WRAP));

    always_comb begin
        state_n  = state;
        count_n  = count;
        dmac_n   = dmac;
        wr_go    = 1'b0;
        wr_slot  = nextbuf[NBUF_LOG2-1:0];
        wr_off   = count[BUF_BYTES_LOG2-1:0];
        commit   = 1'b0;
        inc_ok   = 1'b0;
        inc_full = 1'b0;
        inc_filt = 1'b0;
        inc_err  = 1'b0;
        case (state)
            IDLE, COMMIT: begin
                if (state == COMMIT) begin
                    commit  = 1'b1;
                    inc_ok  = 1'b1;
                    state_n = IDLE;
                end
                if (rx_tvalid) begin
                    if (mid) begin
                        // tail of a frame cut by reset
                        state_n = rx_tlast ? IDLE : DISCARD;
                    end else if (admit_full) begin
                        inc_full = 1'b1;
                        state_n  = rx_tlast ? IDLE : DISCARD;
                    end else begin
                        wr_go   = 1'b1;
                        wr_slot = admit_ptr[NBUF_LOG2-1:0];
                        wr_off  = '0;
                        dmac_n  = dmac_sh[39:0];
                        count_n = CW'(1);
                        if (rx_tlast) begin
                            inc_err = 1'b1;
                            state_n = IDLE;
                        end else begin
                            state_n = HDR;
                        end
                    end
                end
            end
            HDR: begin
                if (rx_tvalid) begin
                    wr_go   = 1'b1;
                    dmac_n  = dmac_sh[39:0];
                    count_n = count + 1'b1;
                    if (rx_tlast) begin
                        inc_err = 1'b1;
                        state_n = IDLE;
                    end else if (count == CW'(5)) begin
                        if (hit) begin
                            state_n = ACCEPT;
                        end else begin
                            inc_filt = 1'b1;
                            state_n  = DISCARD;
                        end
                    end
                end
            end
            ACCEPT: begin
                if (rx_tvalid) begin
                    wr_go   = 1'b1;
                    count_n = count + 1'b1;
                    if (rx_tlast) begin
                        // A frame that exactly fills the slot cannot be
                        // expressed in the length field, so it is rejected too.
                        if (rx_tuser || (count + 1'b1) < MIN_C || count == LAST_OFF) begin
                            inc_err = 1'b1;
                            state_n = IDLE;
                        end else begin
                            state_n = COMMIT;
                        end
                    end else if (count == LAST_OFF) begin
                        inc_err = 1'b1;
                        state_n = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (rx_tvalid && rx_tlast) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Tracks the upstream framing only; deliberately not reset, so beats
    // left over from a frame interrupted by rstn are recognised and dropped.
    always_ff @(posedge i_erx_clk) begin
        if (rx_tvalid) mid <= !rx_tlast;
    end

    always_ff @(posedge i_erx_clk) begin
        if (!rstn) begin
            state     <= IDLE;
            count     <= '0;
            dmac      <= '0;
            fb_s1     <= '0;
            fb_s2     <= '0;
            nextbuf   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            len_we    <= 1'b0;
            len_slot  <= '0;
            len_value <= '0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            dmac    <= dmac_n;
            fb_s1   <= firstbuf_i;
            fb_s2   <= fb_s1;
            wr_en   <= wr_go;
            if (wr_go) begin
                wr_addr <= {wr_slot, wr_off};
                wr_data <= rx_tdata;
            end
            len_we <= commit;
            if (commit) begin
                len_slot  <= nextbuf[NBUF_LOG2-1:0];
                len_value <= count[BUF_BYTES_LOG2-1:0];
                nextbuf   <= nextbuf + 1'b1;
            end
        end
    end

`ifdef ETH_RX_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
        return (inc && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

    always_ff @(posedge i_erx_clk) begin
        if (!rstn || stats_clr) begin
            stat_rx_ok     <= '0;
            stat_drop_full <= '0;
            stat_drop_filt <= '0;
            stat_drop_err  <= '0;
        end else begin
            stat_rx_ok     <= sat_inc(stat_rx_ok, inc_ok);
            stat_drop_full <= sat_inc(stat_drop_full, inc_full);
            stat_drop_filt <= sat_inc(stat_drop_filt, inc_filt);
            stat_drop_err  <= sat_inc(stat_drop_err, inc_err);
        end
    end
`else
    assign stat_rx_ok     = '0;
    assign stat_drop_full = '0;
    assign stat_drop_filt = '0;
    assign stat_drop_err  = '0;
    logic unused_stats;
    assign unused_stats = ^{stats_clr, inc_ok, inc_full, inc_filt, inc_err};
`endif
endmodule

// File: tb/tb_eth_rx_ring_sched.sv
module tb_eth_rx_ring_sched;
`ifdef ETH_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [47:0] MAC   = 48'h02_11_22_33_44_55;
    localparam logic [47:0] OTHER = 48'h02_11_22_33_44_66;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST = 48'h01_00_5E_01_02_03;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid, rx_tlast, rx_tuser;
    logic        promiscuous;
    logic [3:0]  firstbuf_i;
    logic        wr_en, len_we, full, stats_clr;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  len_slot;
    logic [10:0] len_value;
    logic [3:0]  nextbuf;
    logic [15:0] stat_rx_ok, stat_drop_full, stat_drop_filt, stat_drop_err;

    always #5 clk = ~clk;

    eth_rx_ring_sched dut (
        .i_erx_clk(clk), .rstn(rstn),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
        .mac_address(MAC), .promiscuous(promiscuous), .firstbuf_i(firstbuf_i),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len_we(len_we), .len_slot(len_slot), .len_value(len_value),
        .nextbuf(nextbuf), .full(full),
        .stat_rx_ok(stat_rx_ok), .stat_drop_full(stat_drop_full),
        .stat_drop_filt(stat_drop_filt), .stat_drop_err(stat_drop_err),
        .stats_clr(stats_clr)
    );

    // write / commit monitor, sampled on the falling edge
    int          n_wr = 0, n_len = 0;
    logic [13:0] last_waddr = '0;
    logic [2:0]  last_slot = '0, prev_slot = '0;
    logic [10:0] last_len = '0;
    always @(negedge clk) begin
        if (wr_en) begin
            n_wr++;
            last_waddr = wr_addr;
        end
        if (len_we) begin
            n_len++;
            prev_slot = last_slot;
            last_slot = len_slot;
            last_len  = len_value;
        end
    end

    int vecs = 0, miscompares = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int len, input logic [47:0] da, input bit bad);
        for (int i = 0; i < len; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = (i < 6) ? da[47-8*i -: 8] : 8'(i);
            rx_tlast  = (i == len - 1);
            rx_tuser  = bad && (i == len - 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    int w0, l0, k;

    initial begin
        rstn = 1'b0; rx_tdata = '0; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
        promiscuous = 1'b0; firstbuf_i = 4'h0; stats_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_len_we", len_we, 0);
        chk("rst_nextbuf", nextbuf, 0);
        chk("rst_full", full, 0);
        rstn = 1'b1;
        idle(2);

        // good 64-byte frame to the station MAC
        w0 = n_wr; l0 = n_len;
        send(64, MAC, 0); idle(4);
        chk("good_nwr", n_wr - w0, 64);
        chk("good_last_off", last_waddr[10:0], 63);
        chk("good_wr_slot", last_waddr[13:11], 0);
        chk("good_nlen", n_len - l0, 1);
        chk("good_len_slot", last_slot, 0);
        chk("good_len_val", last_len, 64);
        chk("good_nextbuf", nextbuf, 1);

        // destination filter
        l0 = n_len;
        send(64, OTHER, 0); idle(4);
        chk("filt_nlen", n_len - l0, 0);
        chk("filt_nextbuf", nextbuf, 1);
        chk("filt_stat", stat_drop_filt, STATS ? 1 : 0);
        promiscuous = 1'b1;
        send(64, OTHER, 0); idle(4);
        promiscuous = 1'b0;
        chk("promisc_nextbuf", nextbuf, 2);
        send(64, BCAST, 0); idle(4);
        chk("bcast_nextbuf", nextbuf, 3);
        send(64, MCAST, 0); idle(4);
        chk("mcast_nextbuf", nextbuf, 4);
        chk("mcast_len_slot", last_slot, 3);

        // error drops
        l0 = n_len;
        send(40, MAC, 0); idle(4);
        chk("short_nextbuf", nextbuf, 4);
        send(64, MAC, 1); idle(4);
        chk("tuser_nextbuf", nextbuf, 4);
        w0 = n_wr;
        send(2100, MAC, 0); idle(4);
        chk("long_nwr", n_wr - w0, 2048);
        chk("long_last_off", last_waddr[10:0], 2047);
        chk("long_wr_slot", last_waddr[13:11], 4);
        chk("err_nlen", n_len - l0, 0);
        chk("err_stat", stat_drop_err, STATS ? 3 : 0);

        // back-to-back: second frame's first byte lands in the COMMIT cycle
        l0 = n_len;
        send(64, MAC, 0); send(64, MAC, 0); idle(4);
        chk("b2b_nlen", n_len - l0, 2);
        chk("b2b_slot0", prev_slot, 4);
        chk("b2b_slot1", last_slot, 5);
        chk("b2b_wr_slot", last_waddr[13:11], 5);
        chk("b2b_nextbuf", nextbuf, 6);
        chk("ok_stat", stat_rx_ok, STATS ? 6 : 0);

        // ring fill with consumer at 0
        rst_pulse(); idle(3);
        l0 = n_len;
        for (int f = 0; f < 9; f++) begin
            send(64, MAC, 0); idle(3);
        end
        chk("fill_nlen", n_len - l0, 8);
        chk("fill_nextbuf", nextbuf, 8);
        chk("fill_full", full, 1);
        chk("fill_stat", stat_drop_full, STATS ? 1 : 0);
        firstbuf_i = 4'h1;
        k = 0;
        while (full && k < 3) begin
            @(posedge clk); #1;
            k++;
        end
        chk("full_release", full, 0);

        // reset in the middle of a frame
        l0 = n_len;
        for (int i = 0; i < 64; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = (i < 6) ? MAC[47-8*i -: 8] : 8'(i);
            rx_tlast  = (i == 63);
            rx_tuser  = 1'b0;
            rstn      = (i != 20);
            @(posedge clk); #1;
        end
        rstn = 1'b1;
        idle(4);
        chk("midrst_nlen", n_len - l0, 0);
        chk("midrst_nextbuf", nextbuf, 0);
        send(64, MAC, 0); idle(4);
        chk("post_rst_slot", last_slot, 0);
        chk("post_rst_nextbuf", nextbuf, 1);

`ifdef ETH_RX_STATS_EN
        // single-byte runts, one per cycle, drive drop_err into saturation
        for (int i = 0; i < 70000; i++) begin
            rx_tvalid = 1'b1; rx_tdata = 8'h00; rx_tlast = 1'b1; rx_tuser = 1'b0;
            @(posedge clk); #1;
        end
        idle(2);
        chk("sat_err", stat_drop_err, 16'hFFFF);
`endif
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        chk("clr_err", stat_drop_err, 0);
        chk("clr_ok", stat_rx_ok, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
